// File: rtl/dms_sup_pkg.sv
// Shared state type, default timing constants and width helper for the dms LDO supervisor.
package dms_sup_pkg;

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    RAMP       = 3'd1,
    GOOD       = 3'd2,
    RETRY_WAIT = 3'd3,
    LOCKOUT    = 3'd4
  } sup_state_t;

  localparam int unsigned DEB_CYC_DEF      = 8;
  localparam int unsigned RAMP_TMO_CYC_DEF = 1024;
  localparam int unsigned RETRY_CYC_DEF    = 256;
  localparam int unsigned MAX_RETRY_DEF    = 3;
  localparam int unsigned RETRY_W          = 2;

  // Counter width able to hold values 0..n-1, never narrower than one bit.
  function automatic int unsigned cnt_w(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/dms_sup_debounce.sv
// Real-valued threshold compare with a saturating consecutive-sample qualifier.
// BELOW=0 qualifies vin >= thresh, BELOW=1 qualifies vin < thresh.
module dms_sup_debounce
  import dms_sup_pkg::*;
#(
  parameter int unsigned DEB_CYC = DEB_CYC_DEF,
  parameter bit          BELOW   = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic clr,
  input  real  vin,
  input  real  thresh,
  output logic qual
);

  localparam int unsigned CW = cnt_w(DEB_CYC + 1);

  logic          hit;
  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    hit   = BELOW ? (vin < thresh) : (vin >= thresh);
    cnt_d = cnt_q;
    if (clr || !en || !hit) begin
      cnt_d = '0;
    end else if (cnt_q != CW'(DEB_CYC)) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign qual = (cnt_q == CW'(DEB_CYC));

endmodule

// File: rtl/dms_ldo_supervisor.sv
// LDO rail supervisor: enable sequencing, debounced power-good with hysteresis, retry and lockout.
// Optional test load (VSS, load_code, iload current) enabled by DMS_LDO_SUP_LOAD_EN.
module dms_ldo_supervisor
  import dms_sup_pkg::*;
#(
  parameter real         PG_HI_FRAC   = 0.92,
  parameter real         PG_LO_FRAC   = 0.88,
  parameter int unsigned DEB_CYC      = DEB_CYC_DEF,
  parameter int unsigned RAMP_TMO_CYC = RAMP_TMO_CYC_DEF,
  parameter int unsigned RETRY_CYC    = RETRY_CYC_DEF,
  parameter int unsigned MAX_RETRY    = MAX_RETRY_DEF
`ifdef DMS_LDO_SUP_LOAD_EN
  ,
  parameter real         RLOAD_MIN    = 1.0e3,
  parameter real         ROUT_OFF     = 1.0e9
`endif
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  real                  vref,
  input  real                  VOUT,
`ifdef DMS_LDO_SUP_LOAD_EN
  input  real                  VSS,
  input  logic [3:0]           load_code,
  output real                  iload,
`endif
  output logic                 ldo_en,
  output logic                 pgood,
  output logic                 fault,
  output sup_state_t           state,
  output logic [RETRY_W-1:0]   retry_cnt
);

  localparam int unsigned TMO_W  = cnt_w(RAMP_TMO_CYC);
  localparam int unsigned WAIT_W = cnt_w(RETRY_CYC);

  sup_state_t         state_q, state_d;
  logic [RETRY_W-1:0] retry_q, retry_d;
  logic [TMO_W-1:0]   tmo_q, tmo_d;
  logic [WAIT_W-1:0]  wait_q, wait_d;
  logic               ldo_en_q, ldo_en_d;
  logic               pgood_q, pgood_d;
  logic               fault_q, fault_d;
  logic               fail;
  logic               hi_qual, lo_qual;
  logic               state_chg;
  real                hi_th, lo_th;

  assign hi_th     = vref * PG_HI_FRAC;
  assign lo_th     = vref * PG_LO_FRAC;
  assign state_chg = (state_d != state_q);

  dms_sup_debounce #(.DEB_CYC(DEB_CYC), .BELOW(1'b0)) u_deb_hi (
    .clk    (clk),
    .rst_n  (rst_n),
    .en     (state_q == RAMP),
    .clr    (state_chg),
    .vin    (VOUT),
    .thresh (hi_th),
    .qual   (hi_qual)
  );

  dms_sup_debounce #(.DEB_CYC(DEB_CYC), .BELOW(1'b1)) u_deb_lo (
    .clk    (clk),
    .rst_n  (rst_n),
    .en     (state_q == GOOD),
    .clr    (state_chg),
    .vin    (VOUT),
    .thresh (lo_th),
    .qual   (lo_qual)
  );

  // Counters default to zero so each is cleared by whichever transition leaves its state.
  always_comb begin
    state_d = state_q;
    retry_d = retry_q;
    tmo_d   = '0;
    wait_d  = '0;
    fail    = 1'b0;
    if (!start) begin
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE: begin
          state_d = RAMP;
          retry_d = '0;
        end
        RAMP: begin
          if (hi_qual) begin
            state_d = GOOD;
          end else if (tmo_q == TMO_W'(RAMP_TMO_CYC - 1)) begin
            fail = 1'b1;
          end else begin
            tmo_d = tmo_q + TMO_W'(1);
          end
        end
        GOOD: begin
          if (lo_qual) fail = 1'b1;
        end
        RETRY_WAIT: begin
          if (wait_q == WAIT_W'(RETRY_CYC - 1)) begin
            state_d = RAMP;
          end else begin
            wait_d = wait_q + WAIT_W'(1);
          end
        end
        LOCKOUT: ;
        default: state_d = IDLE;
      endcase
      if (fail) begin
        if (retry_q == RETRY_W'(MAX_RETRY)) begin
          state_d = LOCKOUT;
        end else begin
          retry_d = retry_q + RETRY_W'(1);
          state_d = RETRY_WAIT;
        end
      end
    end
    ldo_en_d = (state_d == RAMP) || (state_d == GOOD);
    pgood_d  = (state_d == GOOD);
    fault_d  = (state_d == LOCKOUT);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      retry_q  <= '0;
      tmo_q    <= '0;
      wait_q   <= '0;
      ldo_en_q <= 1'b0;
      pgood_q  <= 1'b0;
      fault_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      retry_q  <= retry_d;
      tmo_q    <= tmo_d;
      wait_q   <= wait_d;
      ldo_en_q <= ldo_en_d;
      pgood_q  <= pgood_d;
      fault_q  <= fault_d;
    end
  end

  assign ldo_en    = ldo_en_q;
  assign pgood     = pgood_q;
  assign fault     = fault_q;
  assign state     = state_q;
  assign retry_cnt = retry_q;

`ifdef DMS_LDO_SUP_LOAD_EN
  real rval_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rval_q <= ROUT_OFF;
    end else if ((state_q == GOOD) && (load_code != 4'd0)) begin
      rval_q <= RLOAD_MIN * 15.0 / real'(load_code);
    end else begin
      rval_q <= ROUT_OFF;
    end
  end

  // Current drawn from VOUT into VSS by the resistive test load.
  assign iload = (VOUT - VSS) / rval_q;
`endif

endmodule
